// File: rtl/q_pkg.sv
// Shared types and constants for the Q-table update datapath.
package q_pkg;
  localparam int STATE_W     = 6;
  localparam int NUM_STATES  = 64;
  localparam int NUM_ACTIONS = 4;
  localparam int Q_W         = 16;

  typedef logic signed [Q_W-1:0] q_t;
  typedef q_t [NUM_ACTIONS-1:0]  q_row_t;

  localparam q_t Q_MAX = 16'sh7FFF;
  localparam q_t Q_MIN = 16'sh8000;

  typedef enum logic [1:0] {IDLE, MAX, CALC, WRITE} fsm_t;

  // Slot i lands at bits [16i+15:16i] of the flat read vector.
  function automatic logic [NUM_ACTIONS*Q_W-1:0] pack_row(input q_row_t row);
    pack_row = '0;
    for (int i = 0; i < NUM_ACTIONS; i++) pack_row[i*Q_W +: Q_W] = row[i];
  endfunction
endpackage

// File: rtl/q_max4.sv
// Combinational signed maximum of the four action slots of one state.
module q_max4
  import q_pkg::*;
(
  input  q_row_t q,
  output q_t     max
);
  q_t m01, m23;

  assign m01 = (q[0] > q[1]) ? q[0] : q[1];
  assign m23 = (q[2] > q[3]) ? q[2] : q[3];
  assign max = (m01 > m23) ? m01 : m23;
endmodule

// File: rtl/q_update_unit.sv
// Shift-based Bellman update of a 64x4 Q-table, one transition per 4 cycles,
// with a combinational read port back to the policy generator.
module q_update_unit
  import q_pkg::*;
#(
  parameter int ALPHA_SHIFT = 1,
  parameter int GAMMA_SHIFT = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   upd_valid,
  output logic                   upd_ready,
  input  logic [STATE_W-1:0]     upd_state,
  input  logic [NUM_ACTIONS-1:0] upd_action,
  input  logic [STATE_W-1:0]     upd_next_state,
  input  logic [Q_W-1:0]         upd_reward,
  input  logic [STATE_W-1:0]     rd_state,
  output logic [63:0]            rd_q_values,
  output logic                   done,
  output logic                   err
);
  fsm_t state, state_nxt;

  q_row_t [NUM_STATES-1:0] q_tab;

  logic [STATE_W-1:0]     cur_s, nxt_s;
  logic [NUM_ACTIONS-1:0] act;
  q_t                     reward, maxq, maxq_c, qsa, nq_r, nq_sat;
  logic                   accept, onehot;

  logic signed [16:0] g;
  logic signed [17:0] target;
  logic signed [18:0] delta;
  logic signed [19:0] nq;

  assign upd_ready   = (state == IDLE);
  assign accept      = upd_valid & upd_ready;
  assign onehot      = (upd_action != '0) && ((upd_action & (upd_action - 4'd1)) == '0);
  assign rd_q_values = pack_row(q_tab[rd_state]);

  q_max4 u_max (.q(q_tab[nxt_s]), .max(maxq_c));

  always_comb begin
    qsa = '0;
    for (int i = 0; i < NUM_ACTIONS; i++)
      if (act[i]) qsa = q_tab[cur_s][i];
  end

  // Every step is widened by one bit so nothing wraps before saturation.
  always_comb begin
    g      = 17'(maxq) - 17'(maxq >>> GAMMA_SHIFT);
    target = 18'(reward) + 18'(g);
    delta  = 19'(target) - 19'(qsa);
    nq     = 20'(qsa) + 20'(delta >>> ALPHA_SHIFT);
    if (nq > 20'sd32767)       nq_sat = Q_MAX;
    else if (nq < -20'sd32768) nq_sat = Q_MIN;
    else                       nq_sat = nq[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && onehot) state_nxt = MAX;
      MAX:     state_nxt = CALC;
      CALC:    state_nxt = WRITE;
      WRITE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_tab  <= '0;
      cur_s  <= '0;
      nxt_s  <= '0;
      act    <= '0;
      reward <= '0;
      maxq   <= '0;
      nq_r   <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= (state == WRITE);
      err  <= accept & ~onehot;
      if (accept) begin
        cur_s  <= upd_state;
        nxt_s  <= upd_next_state;
        act    <= upd_action;
        reward <= upd_reward;
      end
      if (state == MAX)  maxq <= maxq_c;
      if (state == CALC) nq_r <= nq_sat;
      if (state == WRITE)
        for (int i = 0; i < NUM_ACTIONS; i++)
          if (act[i]) q_tab[cur_s][i] <= nq_r;
    end
  end
endmodule

// File: tb/tb_q_update_unit.sv
// Directed bench for q_update_unit with hand-computed Bellman results.
module tb_q_update_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        upd_valid = 1'b0;
  logic        upd_ready;
  logic [5:0]  upd_state = '0;
  logic [3:0]  upd_action = '0;
  logic [5:0]  upd_next_state = '0;
  logic [15:0] upd_reward = '0;
  logic [5:0]  rd_state = '0;
  logic [63:0] rd_q_values;
  logic        done;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  q_update_unit #(.ALPHA_SHIFT(1), .GAMMA_SHIFT(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_state(upd_state), .upd_action(upd_action),
    .upd_next_state(upd_next_state), .upd_reward(upd_reward),
    .rd_state(rd_state), .rd_q_values(rd_q_values),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_q(input logic [5:0] s, input string tag, input logic [63:0] exp);
    rd_state = s;
    #1;
    chk(tag, rd_q_values, exp);
  endtask

  // Full accepted update with cycle-exact ready/done checks.
  task automatic do_update(input logic [5:0] s, input logic [3:0] a,
                           input logic [5:0] sn, input logic [15:0] r, input string tag);
    chk({tag, " ready_pre"}, 64'(upd_ready), 64'd1);
    upd_valid = 1'b1; upd_state = s; upd_action = a;
    upd_next_state = sn; upd_reward = r;
    tick();
    upd_valid = 1'b0; upd_state = '0; upd_action = '0;
    upd_next_state = '0; upd_reward = '0;
    for (int k = 1; k <= 3; k++) begin
      chk({tag, " ready_busy"}, 64'(upd_ready), 64'd0);
      chk({tag, " done_early"}, 64'(done), 64'd0);
      tick();
    end
    chk({tag, " done"}, 64'(done), 64'd1);
    chk({tag, " ready_back"}, 64'(upd_ready), 64'd1);
    tick();
    chk({tag, " done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("rst ready", 64'(upd_ready), 64'd1);
    chk("rst done", 64'(done), 64'd0);
    chk("rst err", 64'(err), 64'd0);

    do_update(6'd5, 4'b0010, 6'd6, 16'd256, "basic");
    read_q(6'd5, "basic q5", 64'h0000_0000_0080_0000);

    do_update(6'd4, 4'b0001, 6'd5, 16'd0, "chain");
    read_q(6'd4, "chain q4", 64'h0000_0000_0000_0038);
    read_q(6'd5, "chain q5", 64'h0000_0000_0080_0000);

    do_update(6'd0, 4'b1000, 6'd0, 16'd32767, "sat1");
    read_q(6'd0, "sat1 q0", 64'h3FFF_0000_0000_0000);
    do_update(6'd0, 4'b1000, 6'd0, 16'd32767, "sat2");
    read_q(6'd0, "sat2 q0", 64'h7BFF_0000_0000_0000);
    do_update(6'd0, 4'b1000, 6'd0, 16'd32767, "sat3");
    read_q(6'd0, "sat3 q0", 64'h7FFF_0000_0000_0000);

    // r=-101: delta>>>1 floors to -51
    do_update(6'd7, 4'b0100, 6'd7, 16'hFF9B, "neg");
    read_q(6'd7, "neg q7", 64'h0000_FFCD_0000_0000);

    upd_valid = 1'b1; upd_state = 6'd9; upd_action = 4'b0011;
    upd_next_state = 6'd9; upd_reward = 16'd500;
    tick();
    upd_valid = 1'b0; upd_action = '0;
    chk("inv err", 64'(err), 64'd1);
    chk("inv ready", 64'(upd_ready), 64'd1);
    chk("inv done", 64'(done), 64'd0);
    tick();
    chk("inv err_pulse", 64'(err), 64'd0);
    for (int k = 0; k < 3; k++) begin
      chk("inv no_done", 64'(done), 64'd0);
      tick();
    end
    read_q(6'd9, "inv q9", 64'h0);

    // Valid held through the busy window: exactly one update lands.
    upd_valid = 1'b1; upd_state = 6'd3; upd_action = 4'b0100;
    upd_next_state = 6'd3; upd_reward = 16'd200;
    tick();
    tick();
    tick();
    tick();
    chk("bp done", 64'(done), 64'd1);
    upd_valid = 1'b0;
    tick();
    chk("bp done_pulse", 64'(done), 64'd0);
    for (int k = 0; k < 4; k++) tick();
    read_q(6'd3, "bp q3", 64'h0000_0064_0000_0000);

    // Reset asserted while the update sits in CALC.
    upd_valid = 1'b1; upd_state = 6'd10; upd_action = 4'b0001;
    upd_next_state = 6'd10; upd_reward = 16'd1000;
    tick();
    upd_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    read_q(6'd5, "midrst q5", 64'h0);
    chk("midrst ready", 64'(upd_ready), 64'd1);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("midrst no_done", 64'(done), 64'd0);
      chk("midrst no_err", 64'(err), 64'd0);
      tick();
    end
    for (int s = 0; s < 64; s++) read_q(6'(s), "midrst clear", 64'h0);
    chk("midrst ready_after", 64'(upd_ready), 64'd1);

    do_update(6'd10, 4'b0001, 6'd11, 16'd1000, "post");
    read_q(6'd10, "post q10", 64'h0000_0000_0000_01F4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
